fp_exception_unit: RTL and testbench
====================================

Name: fp_exception_unit

Overview:
Parametrised, pipelined successor to the add/sub exception stage. It sits at the tail of the FP datapath and takes the rounded result, round/sticky bits and input exception vector. It produces:
- the final IEEE-754 result, with overflow/NaN substitution controlled by rounding mode;
- per-operation flags;
- a sticky status register;
- a maskable trap pulse.

Parameters:
EXP_W, 8, exponent width
MAN_W, 23, stored mantissa width; W = 1+EXP_W+MAN_W
LAT, 1, pipeline latency in cycles, legal 1..3
CNT_W, 16, event counter width (used only with FPEXC_COUNTERS_EN)

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset
InValid  in  1  input beat valid
Z  in  W  rounded result from normaliser/rounder
NegE  in  1  result exponent negative (pre-denormal)
R  in  1  round bit
S  in  1  sticky bit
EOF  in  1  exponent overflow from rounder
InputExc  in  5  [4:2] invalid causes (sNaN, inf-inf, NaN operand); [1:0] operand A/B infinite
RMode  in  2  00 RNE, 01 RZ, 10 RUP, 11 RDN
TrapEn  in  5  trap enable mask, same bit order as Flags
ClrStatus  in  1  clear sticky status (and counters)
CntSel  in  3  counter read select 0..4
OutValid  out  1  result/flags valid
P  out  W  final result
Flags  out  5  {Overflow, Underflow, DivideByZero, Invalid, Inexact} for this beat
Status  out  5  sticky OR of Flags since last clear
Trap  out  1  one-cycle trap pulse
CntOut  out  CNT_W  selected event counter

Behaviour:
- Reset (RST_N=0 at CLK edge): OutValid, P, Flags, Status, Trap, CntOut and all pipeline valids are 0. Reset mid-pipeline discards in-flight beats; no OutValid after release until new InValid.
- Latency: a beat sampled with InValid=1 at edge n appears with OutValid=1 after edge n+LAT-1 registers, i.e. visible LAT cycles later. Fully pipelined, one beat per cycle, no backpressure. InValid=0 beats propagate as bubbles; P and Flags hold their last values when OutValid=0.
- Flag equations, evaluated in stage 1:
  - Invalid = |InputExc[4:2]
  - Overflow = EOF & ~Invalid & ~|InputExc[1:0]. Exact infinity from an infinite operand is not overflow.
  - Underflow = NegE & (R|S) & ~Invalid
  - DivideByZero = 0 (add/sub cannot produce it; bit reserved for the multiplier/divider variant)
  - Inexact = ((R|S) | Overflow | Underflow) & ~Invalid
- Result substitution, with sign s = Z[W-1]:
  - Invalid: P = canonical qNaN {0, all-ones exp, 1, zeros}; sign forced to 0.
  - Else Overflow:
    - RNE → ±inf.
    - RZ → ±max finite {s, all-ones exp with LSB 0, all-ones mantissa}.
    - RUP → +inf if s=0, else -max finite.
    - RDN → -inf if s=1, else +max finite.
  - Else P = Z unchanged.
- Status: on each OutValid beat, Status <= Status | Flags.
  - ClrStatus alone: Status <= 0.
  - ClrStatus with OutValid in the same cycle: Status <= Flags of that beat (new event not lost).
  - ClrStatus does not affect in-flight beats.
- Trap: Trap=1 for exactly the cycle OutValid=1 and |(Flags & TrapEn). Evaluated per beat. Back-to-back trapping beats give back-to-back pulses. TrapEn is sampled at the output stage, not at input.
- RMode is sampled with the beat at input and pipelined alongside it. Changing RMode mid-stream affects only later beats.

Optional Feature:
FPEXC_COUNTERS_EN
- Defined:
  - Five CNT_W-bit counters, one per Flags bit. A counter increments on each OutValid beat with its flag set.
  - Counters saturate at all-ones; no wrap.
  - ClrStatus zeroes them. ClrStatus coinciding with a counted beat loads 1.
  - CntOut = counter[CntSel], registered, 1-cycle read latency. CntSel 5..7 reads 0.
- Undefined: no counter logic; CntOut tied to 0. Port list unchanged.

Test Plan:
- LAT=1, RMode=01, Z=0x7F800000, EOF=1, InputExc=0 → P=0x7F7FFFFF, Flags=5'b10001, OutValid 1 cycle after InValid.
- InputExc=5'b00100, RMode=00 → P=0x7FC00000, Flags=5'b00010. Z=0xFF800000, EOF=1 with RMode=11 → P=0xFF800000, Flags=5'b10001.
- NegE=1, R=0, S=1 → Flags=5'b01001. Then R=S=0, NegE=1 → Flags=0, Status stays 5'b01001. Then ClrStatus with an overflow beat at the output in the same cycle → Status=5'b10001.
- LAT=3, InValid high for 4 consecutive beats, RST_N low one cycle while 2 beats in flight → no OutValid for those beats; all outputs 0 next cycle.
- TrapEn=5'b00010, alternating invalid/valid beats back-to-back → Trap pulses only on invalid beats; TrapEn=0 → Trap never asserts.
- FPEXC_COUNTERS_EN, CNT_W=2: 5 inexact beats → CntSel=0 reads 0 and CntSel=4 reads 3 (saturated); ClrStatus → reads 0.

Source files
------------

// File: rtl/fp_exception_unit.sv
// FP exception tail stage: flags, result substitution, sticky status, trap.
// Define FPEXC_COUNTERS_EN to build per-flag saturating event counters.
module fp_exception_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   InValid,
  input  logic [EXP_W+MAN_W:0]   Z,
  input  logic                   NegE,
  input  logic                   R,
  input  logic                   S,
  input  logic                   EOF,
  input  logic [4:0]             InputExc,
  input  logic [1:0]             RMode,
  input  logic [4:0]             TrapEn,
  input  logic                   ClrStatus,
  input  logic [2:0]             CntSel,
  output logic                   OutValid,
  output logic [EXP_W+MAN_W:0]   P,
  output logic [4:0]             Flags,
  output logic [4:0]             Status,
  output logic                   Trap,
  output logic [CNT_W-1:0]       CntOut
);

  localparam int W = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic         v;
    logic [W-1:0] p;
    logic [4:0]   f;
  } beat_t;

  logic         inv;
  logic         ovf;
  logic         unf;
  logic         inx;
  logic         sgn;
  logic         to_inf;
  logic [W-1:0] inf;
  logic [W-1:0] maxf;
  logic [W-1:0] qnan;
  logic [W-1:0] p1;
  logic [4:0]   f1;

  always_comb begin
    inv  = |InputExc[4:2];
    ovf  = EOF & ~inv & ~|InputExc[1:0];
    unf  = NegE & (R | S) & ~inv;
    inx  = (R | S | ovf | unf) & ~inv;
    f1   = {ovf, unf, 1'b0, inv, inx};
    sgn  = Z[W-1];
    inf  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    maxf = {sgn, {(EXP_W-1){1'b1}}, 1'b0,
            {MAN_W{1'b1}}};
    qnan = {1'b0, {EXP_W{1'b1}}, 1'b1,
            {(MAN_W-1){1'b0}}};
    to_inf = 1'b0;
    unique case (RMode)
      2'b00: to_inf = 1'b1;
      2'b01: to_inf = 1'b0;
      2'b10: to_inf = ~sgn;
      2'b11: to_inf = sgn;
    endcase
    p1 = Z;
    unique case (1'b1)
      inv:     p1 = qnan;
      ovf:     p1 = to_inf ? inf : maxf;
      default: p1 = Z;
    endcase
  end

  beat_t [LAT-1:0] pipe;
  beat_t [LAT-1:0] prv;

  always_comb begin
    prv    = '0;
    prv[0] = '{v: InValid, p: p1, f: f1};
    for (int i = 1; i < LAT; i++)
      prv[i] = pipe[i-1];
  end

  // Payload only loads on valid so the output holds across bubbles.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pipe <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        pipe[i].v <= prv[i].v;
        if (prv[i].v) begin
          pipe[i].p <= prv[i].p;
          pipe[i].f <= prv[i].f;
        end
      end
    end
  end

  beat_t o;
  assign o        = pipe[LAT-1];
  assign OutValid = o.v;
  assign P        = o.p;
  assign Flags    = o.f;
  assign Trap     = o.v & |(o.f & TrapEn);

  always_ff @(posedge CLK) begin
    if (!RST_N)
      Status <= '0;
    else if (ClrStatus)
      Status <= o.v ? o.f : 5'd0;
    else if (o.v)
      Status <= Status | o.f;
  end

`ifdef FPEXC_COUNTERS_EN
  // Counter k tracks Flags bit 4-k (overflow first).
  logic [4:0][CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt    <= '0;
      CntOut <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (ClrStatus)
          cnt[i] <= CNT_W'(o.v & o.f[4-i]);
        else if (o.v && o.f[4-i] && cnt[i] != '1)
          cnt[i] <= cnt[i] + 1'b1;
      end
      case (CntSel)
        3'd0:    CntOut <= cnt[0];
        3'd1:    CntOut <= cnt[1];
        3'd2:    CntOut <= cnt[2];
        3'd3:    CntOut <= cnt[3];
        3'd4:    CntOut <= cnt[4];
        default: CntOut <= '0;
      endcase
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^CntSel;
  assign CntOut     = '0;
`endif

endmodule

// File: tb/tb_fp_exception_unit.sv
// Bench for fp_exception_unit: LAT=1 and LAT=3 instances vs a queue model.
// Directed literal checks followed by randomized traffic.
module tb_fp_exception_unit;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int W  = 1 + EW + MW;
  localparam int CW = 2;

  logic          CLK = 0;
  logic          RST_N = 0;
  logic          InValid = 0;
  logic [W-1:0]  Z = '0;
  logic          NegE = 0, R = 0, S = 0, EOF = 0;
  logic [4:0]    InputExc = '0;
  logic [1:0]    RMode = '0;
  logic [4:0]    TrapEn = '0;
  logic          ClrStatus = 0;
  logic [2:0]    CntSel = '0;

  logic          ov [2];
  logic [W-1:0]  p  [2];
  logic [4:0]    fl [2];
  logic [4:0]    st [2];
  logic          tr [2];
  logic [CW-1:0] co [2];

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit         v;
    bit [W-1:0] p;
    bit [4:0]   f;
  } mb_t;

  function automatic mb_t ref_beat(bit [W-1:0] z, bit nege,
                                   bit r, bit s, bit eof,
                                   bit [4:0] exc, bit [1:0] rm);
    mb_t m;
    bit inv, ovf, unf, inx, neg, up;
    longint unsigned infv, qnan, res;
    inv  = exc[4:2] != 0;
    ovf  = eof && !inv && exc[1:0] == 0;
    unf  = nege && (r || s) && !inv;
    inx  = (r || s || ovf || unf) && !inv;
    neg  = z[W-1];
    infv = (((64'd1 << EW) - 1) << MW)
           | (neg ? (64'd1 << (W-1)) : 64'd0);
    qnan = ((64'd1 << (EW+1)) - 1) << (MW-1);
    up   = (rm == 0) || (rm == 2 && !neg) || (rm == 3 && neg);
    if (inv)      res = qnan;
    else if (ovf) res = up ? infv : infv - 1;
    else          res = 64'(z);
    m.v = 1;
    m.p = res[W-1:0];
    m.f = {ovf, unf, 1'b0, inv, inx};
    return m;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_u
    localparam int L = (k == 0) ? 1 : 3;

    fp_exception_unit #(
      .EXP_W(EW), .MAN_W(MW), .LAT(L), .CNT_W(CW)
    ) dut (
      .CLK(CLK), .RST_N(RST_N), .InValid(InValid), .Z(Z),
      .NegE(NegE), .R(R), .S(S), .EOF(EOF),
      .InputExc(InputExc), .RMode(RMode), .TrapEn(TrapEn),
      .ClrStatus(ClrStatus), .CntSel(CntSel),
      .OutValid(ov[k]), .P(p[k]), .Flags(fl[k]),
      .Status(st[k]), .Trap(tr[k]), .CntOut(co[k])
    );

    mb_t           q[$];
    mb_t           cur;
    logic [4:0]    mst;
    int            cnt [5];
    logic [CW-1:0] mco;
    bit            live = 0;

    always @(posedge CLK) begin
      if (!RST_N) begin
        mb_t z0;
        z0 = '{default: 0};
        q.delete();
        for (int i = 0; i < L - 1; i++) q.push_back(z0);
        cur  = z0;
        mst  = '0;
        mco  = '0;
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        live = 1;
      end else if (live) begin
        mb_t b, nb;
`ifdef FPEXC_COUNTERS_EN
        mco = (CntSel < 5) ? CW'(cnt[CntSel]) : '0;
        for (int i = 0; i < 5; i++) begin
          if (ClrStatus)
            cnt[i] = (cur.v && cur.f[4-i]) ? 1 : 0;
          else if (cur.v && cur.f[4-i] && cnt[i] < (1 << CW) - 1)
            cnt[i] = cnt[i] + 1;
        end
`else
        mco = '0;
`endif
        if (ClrStatus)  mst = cur.v ? cur.f : 5'd0;
        else if (cur.v) mst = mst | cur.f;
        nb = ref_beat(Z, NegE, R, S, EOF, InputExc, RMode);
        nb.v = InValid;
        q.push_back(nb);
        b = q.pop_front();
        cur.v = b.v;
        if (b.v) begin
          cur.p = b.p;
          cur.f = b.f;
        end
      end
    end

    always @(negedge CLK) begin
      if (live) begin
        chk($sformatf("ov%0d", k), ov[k], cur.v);
        chk($sformatf("P%0d", k), p[k], cur.p);
        chk($sformatf("Flags%0d", k), fl[k], cur.f);
        chk($sformatf("Status%0d", k), st[k], mst);
        chk($sformatf("Trap%0d", k), tr[k],
            cur.v && (cur.f & TrapEn) != 0);
        chk($sformatf("CntOut%0d", k), co[k], mco);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] z, input logic nege,
                      input logic r, input logic s,
                      input logic eof, input logic [4:0] exc,
                      input logic [1:0] rm);
    InValid  = 1;
    Z        = z;
    NegE     = nege;
    R        = r;
    S        = s;
    EOF      = eof;
    InputExc = exc;
    RMode    = rm;
    step();
    InValid  = 0;
  endtask

  initial begin
    step();
    step();
    RST_N = 1;
    chk("rst_ov", {ov[0], ov[1]}, 2'b00);
    chk("rst_p", p[0], 32'h0);
    chk("rst_st", st[0], 5'b0);

    beat(32'h7F800000, 0, 0, 0, 1, 5'b0, 2'b01);
    chk("rz_p", p[0], 32'h7F7FFFFF);
    chk("rz_f", fl[0], 5'b10001);
    chk("lat1_ov", ov[0], 1'b1);
    chk("lat3_ov", ov[1], 1'b0);

    beat(32'h3F800000, 0, 0, 0, 0, 5'b00100, 2'b00);
    chk("nan_p", p[0], 32'h7FC00000);
    chk("nan_f", fl[0], 5'b00010);

    beat(32'hFF800000, 0, 0, 0, 1, 5'b0, 2'b11);
    chk("rdn_p", p[0], 32'hFF800000);
    chk("rdn_f", fl[0], 5'b10001);

    ClrStatus = 1;
    step();
    chk("clr_hit", st[0], 5'b10001);
    step();
    chk("clr_only", st[0], 5'b0);
    ClrStatus = 0;

    beat(32'h00400000, 1, 0, 1, 0, 5'b0, 2'b00);
    chk("unf_f", fl[0], 5'b01001);
    beat(32'h00400000, 1, 0, 0, 0, 5'b0, 2'b00);
    chk("exact_f", fl[0], 5'b0);
    chk("sticky1", st[0], 5'b01001);
    step();
    chk("sticky2", st[0], 5'b01001);

    TrapEn = 5'b00010;
    for (int i = 0; i < 6; i++) begin
      beat(32'h40000000, 0, 1, 0, 0,
           (i % 2 == 0) ? 5'b10000 : 5'b0, 2'b00);
      chk("trap_alt", tr[0], i % 2 == 0);
    end
    TrapEn = 5'b0;
    for (int i = 0; i < 3; i++) begin
      beat(32'h40000000, 0, 0, 0, 0, 5'b01000, 2'b00);
      chk("trap_off", tr[0], 1'b0);
    end

    for (int i = 0; i < 4; i++)
      beat(32'h7F000000 + i, 0, 0, 0, 1, 5'b0, 2'b00);
    RST_N = 0;
    step();
    RST_N = 1;
    chk("mid_rst_ov", {ov[0], ov[1]}, 2'b00);
    chk("mid_rst_p", p[1], 32'h0);
    chk("mid_rst_f", fl[1], 5'b0);
    chk("mid_rst_st", st[1], 5'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_ov", ov[1], 1'b0);
    end

`ifdef FPEXC_COUNTERS_EN
    ClrStatus = 1;
    step();
    ClrStatus = 0;
    for (int i = 0; i < 5; i++)
      beat(32'h3F800000, 0, 1, 0, 0, 5'b0, 2'b00);
    CntSel = 3'd4;
    step();
    step();
    chk("cnt_inx_sat", co[0], 2'd3);
    CntSel = 3'd0;
    step();
    chk("cnt_ovf", co[0], 2'd0);
    ClrStatus = 1;
    step();
    ClrStatus = 0;
    CntSel = 3'd4;
    step();
    chk("cnt_clr", co[0], 2'd0);
`else
    CntSel = 3'd4;
    step();
    chk("cnt_off", co[0], 2'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      RST_N     = $urandom_range(0, 99) != 0;
      InValid   = $urandom_range(0, 3) != 0;
      Z         = $urandom;
      if ($urandom_range(0, 3) == 0) Z[W-2:MW] = '1;
      NegE      = $urandom_range(0, 1) == 1;
      R         = $urandom_range(0, 1) == 1;
      S         = $urandom_range(0, 1) == 1;
      EOF       = $urandom_range(0, 2) == 0;
      InputExc  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
      RMode     = 2'($urandom);
      TrapEn    = 5'($urandom);
      ClrStatus = $urandom_range(0, 9) == 0;
      CntSel    = 3'($urandom);
      step();
    end
    RST_N = 1;
    InValid = 0;
    ClrStatus = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
